// File: rtl/cmov_wb_stage_pkg.sv
// Shared processor definitions for the writeback stage: data/address widths,
// buffer occupancy encoding and the commit-counter ceiling.
package cmov_wb_stage_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [15:0] CMOV_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cmov_wb_stage_fwd_match.sv
// Picks the youngest valid buffered result whose rd matches a decode operand address.
// Purely combinational; address 0 never hits and a miss returns zero.
module wb_fwd_match #(
  parameter int DW = cmov_wb_stage_pkg::DW,
  parameter int AW = cmov_wb_stage_pkg::AW
) (
  input  logic [AW-1:0] addr,
  input  logic          old_vld,
  input  logic [AW-1:0] old_rd,
  input  logic [DW-1:0] old_val,
  input  logic          yng_vld,
  input  logic [AW-1:0] yng_rd,
  input  logic [DW-1:0] yng_val,
  output logic          hit,
  output logic [DW-1:0] val
);

  always_comb begin
    hit = 1'b0;
    val = '0;
    if (addr != '0) begin
      if (yng_vld && (yng_rd == addr)) begin
        hit = 1'b1;
        val = yng_val;
      end else if (old_vld && (old_rd == addr)) begin
        hit = 1'b1;
        val = old_val;
      end
    end
  end

endmodule

// File: rtl/cmov_wb_stage.sv
// Writeback stage: 2-entry in-order buffer to the register file with operand forwarding.
// Push-to-rf_we latency 1 cycle when empty; ex_ready drops when full, rf_ready stalls the head.
module cmov_wb_stage
  import cmov_wb_stage_pkg::*;
#(
  parameter int DW = cmov_wb_stage_pkg::DW,
  parameter int AW = cmov_wb_stage_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_result,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_regwrite,
  input  logic          ex_iscmov,
  output logic          rf_we,
  input  logic          rf_ready,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] fw_rs_addr,
  input  logic [AW-1:0] fw_rt_addr,
  output logic          fw_rs_hit,
  output logic          fw_rt_hit,
  output logic [DW-1:0] fw_rs_val,
  output logic [DW-1:0] fw_rt_val,
  output logic [15:0]   cmov_count
);

  occ_e          occ_q, occ_d;
  logic          rd_ptr_q, wr_ptr_q;
  logic [DW-1:0] res_q [2];
  logic [AW-1:0] rd_q  [2];
  logic          cm_q  [2];
  logic [15:0]   cnt_q;
  logic          push, pop;

  // Reset gates ex_ready directly so nothing is accepted while rst is held.
  assign ex_ready   = !rst && (occ_q != OCC_FULL);
  assign push       = ex_valid && ex_ready && ex_regwrite && (ex_rd != '0);
  assign rf_we      = (occ_q != OCC_EMPTY);
  assign pop        = rf_we && rf_ready;
  assign rf_waddr   = rd_q[rd_ptr_q];
  assign rf_wdata   = res_q[rd_ptr_q];
  assign cmov_count = cnt_q;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10: occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01: occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= OCC_EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (pop && cm_q[rd_ptr_q] && (cnt_q != CMOV_CNT_MAX)) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Payload storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_ptr_q] <= ex_result;
      rd_q[wr_ptr_q]  <= ex_rd;
      cm_q[wr_ptr_q]  <= ex_iscmov;
    end
  end

  wb_fwd_match #(.DW(DW), .AW(AW)) u_fwd_rs (
    .addr    (fw_rs_addr),
    .old_vld (occ_q != OCC_EMPTY),
    .old_rd  (rd_q[rd_ptr_q]),
    .old_val (res_q[rd_ptr_q]),
    .yng_vld (occ_q == OCC_FULL),
    .yng_rd  (rd_q[~rd_ptr_q]),
    .yng_val (res_q[~rd_ptr_q]),
    .hit     (fw_rs_hit),
    .val     (fw_rs_val)
  );

  wb_fwd_match #(.DW(DW), .AW(AW)) u_fwd_rt (
    .addr    (fw_rt_addr),
    .old_vld (occ_q != OCC_EMPTY),
    .old_rd  (rd_q[rd_ptr_q]),
    .old_val (res_q[rd_ptr_q]),
    .yng_vld (occ_q == OCC_FULL),
    .yng_rd  (rd_q[~rd_ptr_q]),
    .yng_val (res_q[~rd_ptr_q]),
    .hit     (fw_rt_hit),
    .val     (fw_rt_val)
  );

endmodule
